lsu_stage: RTL and testbench
============================

Name: lsu_stage

Overview:
- Memory-access stage of the RV32I pipeline, between the execute stage and the writeback stage.
- Takes the executed instruction (opcode, funct3, ALU result/address, store data, PC) and performs loads and stores through a req/gnt/rvalid data-memory port.
- Sign/zero-extends load data and presents registered lsu_data / lsu_rslt / lsu_opcode / lsu_PC to writeback.
- Stalls execute while an access is outstanding.

Parameters:
- REG_WIDTH, 32, data/address width; only 32 is supported.
- PC_WIDTH, 32, program counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage accepts an instruction this cycle
- ex_opcode  in  7  instruction opcode
- ex_funct3  in  3  width/sign selector for loads and stores
- ex_rslt  in  REG_WIDTH  ALU result; byte address for loads and stores
- ex_store_data  in  REG_WIDTH  rs2 value for stores
- ex_PC  in  PC_WIDTH  instruction PC
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  REG_WIDTH  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  REG_WIDTH  lane-replicated store data
- dmem_be  out  4  byte enables (stores); 4'b1111 for loads
- dmem_gnt  in  1  memory accepts the request this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  REG_WIDTH  raw load word
- lsu_valid  out  1  output registers hold a completed instruction
- lsu_opcode  out  7  completed opcode; 0 on bubble
- lsu_rslt  out  REG_WIDTH  completed ex_rslt
- lsu_data  out  REG_WIDTH  extended load data; 0 for non-loads
- lsu_PC  out  PC_WIDTH  completed PC
- lsu_fault  out  1  one-cycle pulse: misaligned or illegal-funct3 access dropped

Behaviour:
- Reset (synchronous, wins over all other events):
  - FSM goes to IDLE.
  - All outputs go to 0, except ex_ready = 1 and dmem_be = 0.
  - Reset mid-access drops the access. dmem_req falls the next cycle. A later dmem_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT. ex_ready = (state == IDLE).
- Acceptance: ex_valid && ex_ready at a rising edge.
- Output registers update every cycle. In any cycle with no completion they load a bubble: lsu_valid = 0, lsu_opcode = 0, lsu_rslt = 0, lsu_data = 0, lsu_PC = 0. Writeback therefore never repeats a write.
- Non-memory opcode accepted:
  - Outputs load ex_* at that edge (latency 1). lsu_data = 0.
  - FSM stays in IDLE.
- LOAD (0000011) or STORE (0100011) accepted, aligned and legal:
  - Address, funct3, opcode, PC and store data are captured.
  - FSM goes to REQ. Outputs load a bubble.
- REQ state:
  - dmem_req = 1. dmem_addr, dmem_we, dmem_wdata and dmem_be are driven from the captured registers and held stable until gnt.
  - gnt on a store: store completes. Outputs load opcode/rslt/PC with lsu_data = 0. FSM goes to IDLE. Minimum store latency is 2 cycles.
  - gnt on a load: FSM goes to WAIT. dmem_req drops.
- WAIT state:
  - dmem_req = 0. rvalid is sampled only here, so the earliest rvalid is the cycle after gnt.
  - On rvalid: extended data goes into lsu_data, the load completes, FSM goes to IDLE. Minimum load latency is 3 cycles.
- Load extension (off = addr[1:0]):
  - LB (funct3 0): sign-extend rdata byte at off.
  - LBU (funct3 4): zero-extend rdata byte at off.
  - LH (funct3 1): sign-extend rdata halfword at off[1].
  - LHU (funct3 5): zero-extend rdata halfword at off[1].
  - LW (funct3 2): full word.
- Store lanes:
  - SB: wdata = byte replicated ×4, be = 4'b0001 << off.
  - SH: wdata = halfword replicated ×2, be = off[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = data, be = 4'b1111.
- Fault conditions:
  - Halfword access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 >= 3.
- Fault response:
  - No memory request is issued. FSM stays in IDLE.
  - Outputs load a bubble, so the faulting opcode never reaches writeback.
  - lsu_fault = 1 for one cycle, registered with the outputs.
- Back-to-back: ex_ready returns to 1 in the same cycle the FSM re-enters IDLE, so the next instruction can be accepted the cycle after completion.
- dmem_gnt and dmem_rvalid are ignored in IDLE.

Test Plan:
- Reset: rst = 1 for 2 cycles while in WAIT -> lsu_valid = 0, dmem_req = 0, ex_ready = 1. A stray rvalid after reset leaves outputs at bubble.
- ADD pass-through: OP opcode, ex_rslt = 0x0000_0005, PC = 0x100 -> next cycle lsu_valid = 1, lsu_opcode = 0110011, lsu_rslt = 5, lsu_data = 0.
- LB sign extension: addr 0x1003, rdata 0x80FF_1234 -> dmem_addr 0x1000, lsu_data = 0xFFFF_FF80. Same access as LBU -> 0x0000_0080. gnt held 0 for 3 cycles keeps dmem_req = 1, addr stable, ex_ready = 0.
- SH at 0x2002, data 0x0000_ABCD, gnt immediately -> dmem_wdata = 0xABCD_ABCD, be = 4'b1100, dmem_we = 1. Completion after 2 cycles with lsu_data = 0.
- Misaligned LW at 0x3001 -> no dmem_req, lsu_fault pulses 1 cycle, lsu_opcode = 0. A following LW at 0x3004 is accepted the next cycle.
- Back-to-back SW, LW, ADD with gnt/rvalid at the earliest cycle -> completions at cycles 2, 5, 6 after the first acceptance. No duplicate lsu_valid.

Source files
------------

// File: rtl/lsu_stage.sv
// Memory-access stage of the RV32I pipeline.
// Non-memory instructions pass straight through to writeback with one cycle
// of latency. Loads and stores are captured, issued on a req/gnt/rvalid data
// port, and held until the access completes, stalling execute meanwhile.
// Misaligned accesses and illegal funct3 encodings are dropped and flagged.

module lsu_stage #(
   parameter int REG_WIDTH = 32,
   parameter int PC_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 rst,

   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic [6:0]           ex_opcode,
   input  logic [2:0]           ex_funct3,
   input  logic [REG_WIDTH-1:0] ex_rslt,
   input  logic [REG_WIDTH-1:0] ex_store_data,
   input  logic [PC_WIDTH-1:0]  ex_PC,

   output logic                 dmem_req,
   output logic                 dmem_we,
   output logic [REG_WIDTH-1:0] dmem_addr,
   output logic [REG_WIDTH-1:0] dmem_wdata,
   output logic [3:0]           dmem_be,
   input  logic                 dmem_gnt,
   input  logic                 dmem_rvalid,
   input  logic [REG_WIDTH-1:0] dmem_rdata,

   output logic                 lsu_valid,
   output logic [6:0]           lsu_opcode,
   output logic [REG_WIDTH-1:0] lsu_rslt,
   output logic [REG_WIDTH-1:0] lsu_data,
   output logic [PC_WIDTH-1:0]  lsu_PC,
   output logic                 lsu_fault
);

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [REG_WIDTH-1:0] cap_addr;
   logic [REG_WIDTH-1:0] cap_sdata;
   logic [2:0]           cap_funct3;
   logic [6:0]           cap_opcode;
   logic [PC_WIDTH-1:0]  cap_pc;
   logic                 cap_store;

   logic                 is_load;
   logic                 is_store;
   logic                 is_mem;
   logic                 ex_fault;
   logic                 accept;
   logic                 start_mem;

   logic [7:0]           ld_byte;
   logic [15:0]          ld_half;
   logic [REG_WIDTH-1:0] ld_ext;

   assign is_load   = (ex_opcode == OPC_LOAD);
   assign is_store  = (ex_opcode == OPC_STORE);
   assign is_mem    = is_load || is_store;
   assign accept    = ex_valid && (state_q == ST_IDLE);
   assign start_mem = accept && is_mem && !ex_fault;

   // Classify the incoming memory access as misaligned or illegally encoded
   always_comb begin
      ex_fault = 1'b0;
      if (is_load) begin
         case (ex_funct3)
            3'd0, 3'd4: ex_fault = 1'b0;
            3'd1, 3'd5: ex_fault = ex_rslt[0];
            3'd2:       ex_fault = |ex_rslt[1:0];
            default:    ex_fault = 1'b1;
         endcase
      end else if (is_store) begin
         case (ex_funct3)
            3'd0:    ex_fault = 1'b0;
            3'd1:    ex_fault = ex_rslt[0];
            3'd2:    ex_fault = |ex_rslt[1:0];
            default: ex_fault = 1'b1;
         endcase
      end
   end

   // State register for the access sequencer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and memory port drive; the port is quiet outside REQ
   always_comb begin
      state_d    = state_q;
      ex_ready   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      dmem_be    = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            ex_ready = 1'b1;
            if (start_mem) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            dmem_req  = 1'b1;
            dmem_we   = cap_store;
            dmem_addr = {cap_addr[REG_WIDTH-1:2], 2'b00};
            if (cap_store) begin
               case (cap_funct3[1:0])
                  2'd0: begin
                     dmem_wdata = {4{cap_sdata[7:0]}};
                     dmem_be    = 4'b0001 << cap_addr[1:0];
                  end
                  2'd1: begin
                     dmem_wdata = {2{cap_sdata[15:0]}};
                     dmem_be    = cap_addr[1] ? 4'b1100 : 4'b0011;
                  end
                  default: begin
                     dmem_wdata = cap_sdata;
                     dmem_be    = 4'b1111;
                  end
               endcase
            end else begin
               dmem_be = 4'b1111;
            end
            if (dmem_gnt) begin
               state_d = cap_store ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the accepted memory instruction so execute may move on
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_addr   <= '0;
         cap_sdata  <= '0;
         cap_funct3 <= 3'd0;
         cap_opcode <= 7'd0;
         cap_pc     <= '0;
         cap_store  <= 1'b0;
      end else if (start_mem) begin
         cap_addr   <= ex_rslt;
         cap_sdata  <= ex_store_data;
         cap_funct3 <= ex_funct3;
         cap_opcode <= ex_opcode;
         cap_pc     <= ex_PC;
         cap_store  <= is_store;
      end
   end

   // Pick the addressed lane of the returned word and extend it
   always_comb begin
      ld_byte = 8'd0;
      ld_half = cap_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (cap_addr[1:0])
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      case (cap_funct3)
         3'd0:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'd4:    ld_ext = {24'd0, ld_byte};
         3'd1:    ld_ext = {{16{ld_half[15]}}, ld_half};
         3'd5:    ld_ext = {16'd0, ld_half};
         default: ld_ext = dmem_rdata;
      endcase
   end

   // Writeback registers: a bubble every cycle unless something completes
   always_ff @(posedge clk) begin
      if (rst) begin
         lsu_valid  <= 1'b0;
         lsu_opcode <= 7'd0;
         lsu_rslt   <= '0;
         lsu_data   <= '0;
         lsu_PC     <= '0;
         lsu_fault  <= 1'b0;
      end else begin
         lsu_valid  <= 1'b0;
         lsu_opcode <= 7'd0;
         lsu_rslt   <= '0;
         lsu_data   <= '0;
         lsu_PC     <= '0;
         lsu_fault  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept && !is_mem) begin
                  lsu_valid  <= 1'b1;
                  lsu_opcode <= ex_opcode;
                  lsu_rslt   <= ex_rslt;
                  lsu_PC     <= ex_PC;
               end else if (accept && ex_fault) begin
                  lsu_fault  <= 1'b1;
               end
            end
            ST_REQ: begin
               if (dmem_gnt && cap_store) begin
                  lsu_valid  <= 1'b1;
                  lsu_opcode <= cap_opcode;
                  lsu_rslt   <= cap_addr;
                  lsu_PC     <= cap_pc;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid) begin
                  lsu_valid  <= 1'b1;
                  lsu_opcode <= cap_opcode;
                  lsu_rslt   <= cap_addr;
                  lsu_data   <= ld_ext;
                  lsu_PC     <= cap_pc;
               end
            end
            default: begin
               lsu_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_stage.sv
// Testbench for lsu_stage: directed scenarios followed by randomized
// instruction streams, checked against a transaction-level model that
// derives lanes, byte enables, extension and faults arithmetically.

module tb_lsu_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_rslt;
   logic [31:0] ex_store_data;
   logic [31:0] ex_PC;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        lsu_valid;
   logic [6:0]  lsu_opcode;
   logic [31:0] lsu_rslt;
   logic [31:0] lsu_data;
   logic [31:0] lsu_PC;
   logic        lsu_fault;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cyc = 0;

   lsu_stage #(.REG_WIDTH(32), .PC_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode),
      .ex_funct3(ex_funct3), .ex_rslt(ex_rslt), .ex_store_data(ex_store_data),
      .ex_PC(ex_PC),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .lsu_valid(lsu_valid), .lsu_opcode(lsu_opcode), .lsu_rslt(lsu_rslt),
      .lsu_data(lsu_data), .lsu_PC(lsu_PC), .lsu_fault(lsu_fault)
   );

   // Free-running clock and a cycle counter for latency measurements
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int accSize(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic bit mdlFault(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr);
      if (opc != OP_LOAD && opc != OP_STORE) return 1'b0;
      if (opc == OP_LOAD && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
      if (opc == OP_STORE && f3 >= 3'd3) return 1'b1;
      return (addr % accSize(f3)) != 0;
   endfunction

   function automatic logic [3:0] mdlBe(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr);
      int lanes;
      if (opc == OP_LOAD) return 4'hF;
      lanes = (1 << accSize(f3)) - 1;
      return 4'(lanes << (addr % 4));
   endfunction

   function automatic logic [31:0] mdlWdata(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] sd);
      if (opc == OP_LOAD) return 32'd0;
      case (accSize(f3))
         1:       return (sd & 32'hFF) * 32'h0101_0101;
         2:       return (sd & 32'hFFFF) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   function automatic logic [31:0] mdlLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
      int          bits;
      logic [31:0] v;
      logic [31:0] mask;
      bits = 8 * accSize(f3);
      v    = rd >> (8 * (addr % 4));
      if (bits < 32) begin
         mask = (32'h1 << bits) - 32'h1;
         v    = v & mask;
         if (!f3[2] && v[bits-1]) v = v | ~mask;
      end
      return v;
   endfunction

   // One idle cycle with stray memory handshakes that must be ignored
   task automatic idleCycle();
      ex_valid    = 1'b0;
      dmem_gnt    = 1'($urandom % 2);
      dmem_rvalid = 1'($urandom % 2);
      dmem_rdata  = $urandom;
      tick();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      checkOutput("idle_valid", 32'(lsu_valid), 32'd0);
      checkOutput("idle_opcode", 32'(lsu_opcode), 32'd0);
      checkOutput("idle_data", lsu_data, 32'd0);
      checkOutput("idle_fault", 32'(lsu_fault), 32'd0);
      checkOutput("idle_req", 32'(dmem_req), 32'd0);
      checkOutput("idle_ready", 32'(ex_ready), 32'd1);
   endtask

   // Present one instruction, act as memory with the given delays, check all
   task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3,
                                input logic [31:0] rslt, input logic [31:0] sd,
                                input logic [31:0] pc, input int gnt_dly,
                                input int rv_dly, input logic [31:0] rd);
      bit st;
      st = (opc == OP_STORE);
      ex_valid      = 1'b1;
      ex_opcode     = opc;
      ex_funct3     = f3;
      ex_rslt       = rslt;
      ex_store_data = sd;
      ex_PC         = pc;
      checkOutput("ready_pre", 32'(ex_ready), 32'd1);
      tick();
      ex_valid      = 1'b0;
      ex_opcode     = 7'($urandom);
      ex_funct3     = 3'($urandom);
      ex_rslt       = $urandom;
      ex_store_data = $urandom;
      ex_PC         = $urandom;
      if (opc != OP_LOAD && opc != OP_STORE) begin
         checkOutput("pass_valid", 32'(lsu_valid), 32'd1);
         checkOutput("pass_opcode", 32'(lsu_opcode), 32'(opc));
         checkOutput("pass_rslt", lsu_rslt, rslt);
         checkOutput("pass_data", lsu_data, 32'd0);
         checkOutput("pass_pc", lsu_PC, pc);
         checkOutput("pass_fault", 32'(lsu_fault), 32'd0);
         done_cyc = cyc;
         return;
      end
      if (mdlFault(opc, f3, rslt)) begin
         checkOutput("flt_valid", 32'(lsu_valid), 32'd0);
         checkOutput("flt_opcode", 32'(lsu_opcode), 32'd0);
         checkOutput("flt_pulse", 32'(lsu_fault), 32'd1);
         checkOutput("flt_req", 32'(dmem_req), 32'd0);
         checkOutput("flt_ready", 32'(ex_ready), 32'd1);
         return;
      end
      checkOutput("acc_valid", 32'(lsu_valid), 32'd0);
      checkOutput("acc_opcode", 32'(lsu_opcode), 32'd0);
      checkOutput("acc_fault", 32'(lsu_fault), 32'd0);
      checkOutput("acc_ready", 32'(ex_ready), 32'd0);
      checkOutput("req", 32'(dmem_req), 32'd1);
      checkOutput("we", 32'(dmem_we), 32'(st));
      checkOutput("addr", dmem_addr, rslt & 32'hFFFF_FFFC);
      checkOutput("wdata", dmem_wdata, mdlWdata(opc, f3, sd));
      checkOutput("be", 32'(dmem_be), 32'(mdlBe(opc, f3, rslt)));
      for (int i = 0; i < gnt_dly; i++) begin
         tick();
         checkOutput("hold_req", 32'(dmem_req), 32'd1);
         checkOutput("hold_addr", dmem_addr, rslt & 32'hFFFF_FFFC);
         checkOutput("hold_ready", 32'(ex_ready), 32'd0);
         checkOutput("hold_valid", 32'(lsu_valid), 32'd0);
      end
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      if (st) begin
         checkOutput("st_valid", 32'(lsu_valid), 32'd1);
         checkOutput("st_opcode", 32'(lsu_opcode), 32'(opc));
         checkOutput("st_rslt", lsu_rslt, rslt);
         checkOutput("st_pc", lsu_PC, pc);
         checkOutput("st_data", lsu_data, 32'd0);
         checkOutput("st_req", 32'(dmem_req), 32'd0);
         checkOutput("st_ready", 32'(ex_ready), 32'd1);
         done_cyc = cyc;
         return;
      end
      checkOutput("wait_req", 32'(dmem_req), 32'd0);
      checkOutput("wait_valid", 32'(lsu_valid), 32'd0);
      checkOutput("wait_ready", 32'(ex_ready), 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
         dmem_rdata = $urandom;
         tick();
         checkOutput("wait_valid", 32'(lsu_valid), 32'd0);
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = rd;
      tick();
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      checkOutput("ld_valid", 32'(lsu_valid), 32'd1);
      checkOutput("ld_opcode", 32'(lsu_opcode), 32'(opc));
      checkOutput("ld_rslt", lsu_rslt, rslt);
      checkOutput("ld_pc", lsu_PC, pc);
      checkOutput("ld_data", lsu_data, mdlLoad(f3, rslt, rd));
      checkOutput("ld_ready", 32'(ex_ready), 32'd1);
      done_cyc = cyc;
   endtask

   // Main sequence: reset, directed cases, reset mid-access, random stream
   initial begin
      int          c0;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [31:0] addr;
      int          pick;

      rst = 1'b1; ex_valid = 1'b0; ex_opcode = 7'd0; ex_funct3 = 3'd0;
      ex_rslt = 32'd0; ex_store_data = 32'd0; ex_PC = 32'd0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      tick();
      tick();
      checkOutput("rst_ready", 32'(ex_ready), 32'd1);
      checkOutput("rst_req", 32'(dmem_req), 32'd0);
      checkOutput("rst_be", 32'(dmem_be), 32'd0);
      checkOutput("rst_valid", 32'(lsu_valid), 32'd0);
      checkOutput("rst_fault", 32'(lsu_fault), 32'd0);
      rst = 1'b0;
      idleCycle();

      applyStimulus(OP_ALU, 3'd0, 32'h5, 32'h0, 32'h100, 0, 0, 32'h0);
      applyStimulus(OP_LOAD, 3'd0, 32'h1003, 32'h0, 32'h104, 3, 0, 32'h80FF_1234);
      applyStimulus(OP_LOAD, 3'd4, 32'h1003, 32'h0, 32'h108, 3, 1, 32'h80FF_1234);
      applyStimulus(OP_STORE, 3'd1, 32'h2002, 32'h0000_ABCD, 32'h10C, 0, 0, 32'h0);
      applyStimulus(OP_LOAD, 3'd2, 32'h3001, 32'h0, 32'h110, 0, 0, 32'h0);
      applyStimulus(OP_LOAD, 3'd2, 32'h3004, 32'h0, 32'h114, 0, 0, 32'hCAFE_F00D);
      idleCycle();

      c0 = cyc;
      applyStimulus(OP_STORE, 3'd2, 32'h4000, 32'h1234_5678, 32'h200, 0, 0, 32'h0);
      checkOutput("b2b_sw_cycle", 32'(done_cyc - c0), 32'd2);
      applyStimulus(OP_LOAD, 3'd2, 32'h4000, 32'h0, 32'h204, 0, 0, 32'h1234_5678);
      checkOutput("b2b_lw_cycle", 32'(done_cyc - c0), 32'd5);
      applyStimulus(OP_ALU, 3'd0, 32'h9, 32'h0, 32'h208, 0, 0, 32'h0);
      checkOutput("b2b_add_cycle", 32'(done_cyc - c0), 32'd6);
      idleCycle();

      ex_valid = 1'b1; ex_opcode = OP_LOAD; ex_funct3 = 3'd2;
      ex_rslt = 32'h40; ex_PC = 32'h300;
      tick();
      ex_valid = 1'b0;
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      rst = 1'b1;
      tick();
      checkOutput("rstw_req", 32'(dmem_req), 32'd0);
      checkOutput("rstw_ready", 32'(ex_ready), 32'd1);
      tick();
      checkOutput("rstw_valid", 32'(lsu_valid), 32'd0);
      checkOutput("rstw_req2", 32'(dmem_req), 32'd0);
      rst = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      tick();
      dmem_rvalid = 1'b0;
      checkOutput("stray_valid", 32'(lsu_valid), 32'd0);
      checkOutput("stray_data", lsu_data, 32'd0);
      checkOutput("stray_ready", 32'(ex_ready), 32'd1);

      for (int n = 0; n < 200; n++) begin
         pick = int'($urandom % 6);
         case (pick)
            0, 1:    opc = OP_LOAD;
            2, 3:    opc = OP_STORE;
            4:       opc = OP_IMM;
            default: opc = ($urandom % 2) ? OP_ALU : OP_LUI;
         endcase
         f3   = 3'($urandom);
         addr = $urandom;
         if ($urandom % 4 != 0) addr = addr & ~(32'(accSize(f3)) - 32'd1);
         applyStimulus(opc, f3, addr, $urandom, $urandom, int'($urandom % 4),
                       int'($urandom % 4), $urandom);
         if ($urandom % 4 == 0) idleCycle();
      end
      idleCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
